// File: rtl/pc_trace_pkg.sv
// Shared constants, state encoding and byte-select helper for the PC trace transmitter.
package pc_trace_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         BYTES_PER_REC = 5;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

  // Record byte idx 1..4 carries PC[31:24] down to PC[7:0]; byte 0 is the sync byte.
  function automatic logic [7:0] pc_byte(input logic [31:0] pc, input logic [2:0] idx);
    case (idx)
      3'd1:    return pc[31:24];
      3'd2:    return pc[23:16];
      3'd3:    return pc[15:8];
      default: return pc[7:0];
    endcase
  endfunction

endpackage

// File: rtl/pc_trace_fifo.sv
// First-word fall-through FIFO holding sampled PCs; rd_data is valid whenever not empty.
module pc_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  // A push into a full FIFO is still accepted when the same cycle frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pc_trace_tx.sv
// PC trace transmitter: buffers retired PCs and sends each as a 5-byte 8N1 record (A5, PC MSB..LSB).
module pc_trace_tx
  import pc_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   pc_in,
  input  logic                          pc_valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(BYTES_PER_REC - 1);

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    shift;
  logic [31:0]   shadow;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_data;
  logic          baud_done;
  logic          rec_done;
  logic          drop;

  assign baud_done = (state != IDLE) && (baud == BAUD_LAST);
  assign rec_done  = (state == STOP) && baud_done && (byte_idx == LAST_BYTE);
  // Pop either from idle or on the edge that ends a record, so records run back to back.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || rec_done);
  assign drop      = pc_valid && fifo_full && !fifo_pop;
  assign busy      = (state != IDLE);

  pc_trace_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (pc_valid),
    .wr_data (pc_in),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // NOTE: always_comb drives tx on every path via a default, so no latch can be inferred.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      shadow   <= '0;
    end else begin
      if (state == IDLE || baud_done) baud <= '0;
      else                            baud <= baud + 1'b1;

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shadow   <= fifo_data;
            shift    <= SYNC_BYTE;
            byte_idx <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_done) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        default: begin
          if (baud_done) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              shift    <= pc_byte(shadow, byte_idx + 3'd1);
              state    <= START;
            end else if (fifo_pop) begin
              shadow   <= fifo_data;
              shift    <= SYNC_BYTE;
              byte_idx <= '0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Drop bookkeeping is sticky until reset; the counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_trace_tx.sv
// Self-checking bench for pc_trace_tx: serial decoder, queue-based reference model, directed and random tests.
module tb_pc_trace_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int REC   = 50 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  pc_trace_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  longint cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: a queue of pending PCs plus the number of cycles left in the current record.
  logic [31:0] qpc[$];
  logic [31:0] cur_pc = '0;
  int          rem = 0;
  bit          m_ovf = 0;
  int          m_drops = 0;
  int          m_recs = 0;
  bit          m_full;
  bit          m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qpc.delete();
      rem = 0; m_ovf = 0; m_drops = 0; m_recs = 0;
    end else begin
      m_full = (qpc.size() == DEPTH);
      m_pop  = (rem <= 1) && (qpc.size() != 0);
      if (m_pop) begin
        cur_pc = qpc.pop_front();
        rem = REC;
        m_recs++;
      end else if (rem > 0) begin
        rem--;
      end
      if (pc_valid) begin
        if (!m_full || m_pop) qpc.push_back(pc_in);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  function automatic logic model_tx();
    int bp, bn, bi;
    logic [7:0] bv;
    if (rem == 0) return 1'b1;
    bp = (REC - rem) / CPB;
    bn = bp / 10;
    bi = bp % 10;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    bv = (bn == 0) ? 8'hA5 : 8'(cur_pc >> (8 * (4 - bn)));
    return bv[bi-1];
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("tx", tx, model_tx());
      check("busy", busy, rem != 0);
      check("fifo_level", fifo_level, qpc.size());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drops);
    end
  end

  int busy_cyc = 0;
  always @(negedge clk) if (busy === 1'b1) busy_cyc++;

  // Serial decoder: samples each bit mid-period and records byte values and start cycles.
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  int         rx_ferr = 0;
  bit         rst_seen = 0;
  always @(negedge rst) rst_seen = 1;

  initial begin : rx_proc
    logic [9:0] bits;
    longint     t0;
    forever begin
      while (!(rst && tx === 1'b0)) begin
        @(posedge clk); #1;
      end
      t0 = cyc;
      rst_seen = 0;
      for (int j = 0; j < 10; j++) begin
        repeat (CPB / 2) @(posedge clk);
        #1 bits[j] = tx;
        repeat (CPB - CPB / 2) @(posedge clk);
      end
      #1;
      if (!rst_seen && rst) begin
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_ferr++;
        else begin
          rx_q.push_back(bits[8:1]);
          rx_t.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] rec_byte(input logic [31:0] pc, input int b);
    logic [39:0] r;
    r = {8'hA5, pc};
    return r[39 - 8*b -: 8];
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_fifo_level", fifo_level, 4'd0);
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    clear_rx();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, rx_q.size() >= n, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_records(input logic [31:0] pcs[$], input string name);
    check({name, "_count"}, rx_q.size(), 5 * pcs.size());
    for (int r = 0; r < pcs.size(); r++)
      for (int b = 0; b < 5; b++)
        if (5*r + b < rx_q.size())
          check($sformatf("%s_r%0d_b%0d", name, r, b), rx_q[5*r+b], rec_byte(pcs[r], b));
    for (int i = 1; i < rx_t.size(); i++)
      check($sformatf("%s_gap%0d", name, i), 32'(rx_t[i] - rx_t[i-1]), 10 * CPB);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [39:0] rec;
  } vec_t;

  initial begin : main
    vec_t        tbl[4];
    logic [31:0] pcs[$];
    int          rates[4];

    tbl[0] = '{pc: 32'h0000_0004, rec: 40'hA5_00_00_00_04};
    tbl[1] = '{pc: 32'hDEAD_BEEF, rec: 40'hA5_DE_AD_BE_EF};
    tbl[2] = '{pc: 32'h8000_0001, rec: 40'hA5_80_00_00_01};
    tbl[3] = '{pc: 32'h00FF_00FF, rec: 40'hA5_00_FF_00_FF};

    do_reset();

    // Single samples: latency, byte content, busy duration, FIFO drained.
    for (int v = 0; v < 4; v++) begin
      clear_rx();
      busy_cyc = 0;
      pc_in = tbl[v].pc;
      pc_valid = 1'b1;
      @(posedge clk); #1;
      pc_valid = 1'b0;
      check("lat_tx_still_idle", tx, 1'b1);
      check("lat_level_one", fifo_level, 4'd1);
      @(posedge clk); #1;
      check("lat_tx_fall", tx, 1'b0);
      wait_bytes(5, REC + 60, "single_bytes_timeout");
      wait_idle(60, "single_idle_timeout");
      check("single_busy_cycles", busy_cyc, REC);
      check("single_level_zero", fifo_level, 4'd0);
      for (int b = 0; b < 5; b++)
        if (b < rx_q.size())
          check($sformatf("single%0d_b%0d", v, b), rx_q[b], tbl[v].rec[39 - 8*b -: 8]);
      check("single_count", rx_q.size(), 5);
    end

    // Burst of 12 into an empty FIFO: 9 accepted, 3 dropped, records back to back.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      pc_in = 32'(4 * i);
      pc_valid = 1'b1;
      @(posedge clk); #1;
    end
    pc_valid = 1'b0;
    check("burst_level", fifo_level, 4'd8);
    check("burst_drop_count", drop_count, 8'd3);
    check("burst_overflow", overflow, 1'b1);
    wait_bytes(45, 9 * REC + 100, "burst_bytes_timeout");
    wait_idle(100, "burst_idle_timeout");
    pcs.delete();
    for (int r = 0; r < 9; r++) pcs.push_back(32'(4 * r));
    check_records(pcs, "burst");

    // Full FIFO with a push on the very edge the FSM pops: accepted, no drop.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pc_in = 32'h1000 + 32'(i);
      pc_valid = 1'b1;
      @(posedge clk); #1;
    end
    pc_valid = 1'b0;
    check("fullpop_level_full", fifo_level, 4'd8);
    repeat (192) @(posedge clk);
    #1;
    check("fullpop_level_before", fifo_level, 4'd8);
    pc_in = 32'hABCD_0000;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    check("fullpop_level_after", fifo_level, 4'd8);
    check("fullpop_drop_count", drop_count, 8'd0);
    check("fullpop_overflow", overflow, 1'b0);
    wait_bytes(50, 10 * REC + 100, "fullpop_bytes_timeout");
    wait_idle(100, "fullpop_idle_timeout");
    pcs.delete();
    for (int r = 0; r < 9; r++) pcs.push_back(32'h1000 + 32'(r));
    pcs.push_back(32'hABCD_0000);
    check_records(pcs, "fullpop");

    // Reset during the PC[23:16] byte with entries still queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h1234_5678 + 32'(i);
      pc_valid = 1'b1;
      @(posedge clk); #1;
    end
    pc_valid = 1'b0;
    repeat (89) @(posedge clk);
    #3;
    check("midrst_level_pre", fifo_level, 4'd2);
    rst = 1'b0;
    #1;
    check("midrst_tx_async", tx, 1'b1);
    check("midrst_busy_async", busy, 1'b0);
    check("midrst_level_async", fifo_level, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    clear_rx();
    pc_in = 32'h0000_0100;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    wait_bytes(5, REC + 60, "midrst_bytes_timeout");
    wait_idle(60, "midrst_idle_timeout");
    pcs.delete();
    pcs.push_back(32'h0000_0100);
    check_records(pcs, "midrst");

    // Saturation: 320 back-to-back samples give 310 drops.
    do_reset();
    pc_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      pc_in = $urandom;
      @(posedge clk); #1;
    end
    pc_valid = 1'b0;
    check("sat_drop_count", drop_count, 8'd255);
    check("sat_overflow", overflow, 1'b1);

    // Random traffic at several rates against the reference model.
    do_reset();
    rates = '{10, 3, 50, 5};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1000; i++) begin
        pc_valid = ($urandom_range(0, 999) < rates[p]);
        pc_in = $urandom;
        @(posedge clk); #1;
      end
    end
    pc_valid = 1'b0;
    wait_idle((DEPTH + 1) * REC + 200, "rand_idle_timeout");
    repeat (4) @(posedge clk);
    #1;
    check("rand_rx_bytes", rx_q.size(), 5 * m_recs);
    check("rand_frame_errors", rx_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_trace_tx.md
# pc_trace_tx

Serial program-counter trace transmitter for the single-cycle RISC-V chip. It samples the core's PC on every retire strobe and buffers the values in a small FIFO. Each value is sent as a framed 5-byte record over a one-wire UART-style 8N1 line, so PC flow can be observed from a pin or by a serial monitor instead of by probing internal wires. It sits beside the core inside the chip top and is driven only by the core's PC and retire signals.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, default 8: number of PC entries buffered; must be a power of 2, ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- pc_in  input  32  PC value from the core.
- pc_valid  input  1  retire strobe; pc_in is sampled on every clk edge where pc_valid=1.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a record is being shifted out.
- overflow  output  1  sticky; set when a sample is dropped because the FIFO is full.
- drop_count  output  8  count of dropped samples; saturates at 255.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: pc_valid=1 and FIFO not full → pc_in is written. If the FIFO is full and no pop happens in the same cycle, the sample is dropped, overflow is set to 1, and drop_count is incremented (held at 255 once it saturates).
- Simultaneous push and pop on a full FIFO: the push is accepted and the level is unchanged.
- Record format: byte 0 = SYNC 8'hA5, then PC[31:24], PC[23:16], PC[15:8], PC[7:0].
- Each byte is sent as 1 start bit (0), 8 data bits LSB-first, and 1 stop bit (1). A record is therefore 50 bit periods.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0. If the FIFO is not empty, pop into a 32-bit shadow register, load SYNC into the shift register, set byte_idx=0, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and advance. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx<4: increment byte_idx, load the next PC byte from the shadow register, and go to START.
  - If byte_idx=4 and the FIFO is not empty: pop the next entry and go to START (back-to-back records with no idle gap).
  - If byte_idx=4 and the FIFO is empty: go to IDLE.
- busy is 1 in START, DATA and STOP.
- overflow and drop_count clear only on reset.

## Timing
- Reset values: tx=1, busy=0, overflow=0, drop_count=0, fifo_level=0, FSM=IDLE, FIFO empty.
- Reset acts asynchronously. Asserting it mid-frame forces tx=1 immediately and discards the partial record and all queued entries.
- Latency with the block idle and FIFO empty: pc_valid sampled at edge N → write at edge N → pop at edge N+1 → tx falls at edge N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles, counted by a baud counter that runs from 0 to CLKS_PER_BIT-1.
- A record lasts 50·CLKS_PER_BIT cycles. busy deasserts on the edge that ends the final stop bit if the FIFO is empty at that point.
- fifo_level updates on the same edge as the push or pop.

## Structure
- Package pc_trace_pkg holds:
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_REC = 5
  - the FSM state typedef (IDLE/START/DATA/STOP)
- Sub-module pc_trace_fifo: synchronous FIFO with parameter depth and width 32, ports push/pop/full/empty/level, and read data valid in the pop cycle (first-word fall-through).
- The top module contains the FSM, baud counter, shift register, shadow register and drop logic.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.

- Reset: hold rst=0 for 2 cycles → tx=1, busy=0, overflow=0, drop_count=0, fifo_level=0.
- Single sample: one pc_valid pulse with pc_in=32'h00000004 →
  - tx falls one cycle after the sample edge;
  - decoded bytes are A5,00,00,00,04;
  - busy is high for exactly 200 cycles;
  - fifo_level returns to 0.
- Burst overflow: 12 consecutive pc_valid cycles with PCs 0x00,0x04,…,0x2C →
  - 9 samples accepted, last 3 dropped;
  - overflow=1, drop_count=3;
  - 9 back-to-back records (PCs 0x00–0x20 in order) with no idle gap between them.
- Full plus pop: fill the FIFO, then issue pc_valid on the same cycle the FSM pops → sample accepted, level stays 8, no drop counted.
- Reset mid-frame: assert rst during the PC[23:16] byte →
  - tx=1 with no clock edge required;
  - FIFO empty;
  - after release, the next sample 32'h00000100 is sent as a clean A5,00,00,01,00 record.
- Saturation: 300 drops while the FIFO is held full → drop_count=255 and overflow=1.
